// File: rtl/ntt_cmd_sched_pkg.sv
// rtl/ntt_cmd_sched_pkg.sv - shared state encodings, limits and error codes for the NTT command scheduler
package ntt_cmd_sched_pkg;

  // Controller state encoding, shared with the opcode field of a command
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] NTT      = 3'd1;
  localparam logic [2:0] PWP      = 3'd2;
  localparam logic [2:0] INTT     = 3'd3;
  localparam logic [2:0] MAO      = 3'd4;
  localparam logic [2:0] EPL_NTT  = 3'd5;
  localparam logic [2:0] EPL_INTT = 3'd6;

  localparam logic [3:0] PMAX_MAX = 4'd9;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OP   = 2'd1;
  localparam logic [1:0] ERR_PMAX = 2'd2;
  localparam logic [1:0] ERR_ACK  = 2'd3;

  localparam int CMD_W = 7;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] pmax;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_RUN,
    S_GAP
  } sched_state_t;

  // PWP/MAO never return to IDLE on their own, so only NTT/INTT are accepted
  function automatic logic [1:0] cmd_check(input cmd_t c);
    if (c.op != NTT && c.op != INTT) return ERR_OP;
    if (c.pmax == 4'd0 || c.pmax > PMAX_MAX) return ERR_PMAX;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/ntt_cmd_sched_fifo.sv
// rtl/ntt_cmd_sched_fifo.sv - ntt_cmd_fifo: synchronous command FIFO with valid/ready push, pop strobe and occupancy
module ntt_cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (count != (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ntt_cmd_sched.sv
// rtl/ntt_cmd_sched.sv - command scheduler in front of the NTT address/twiddle controller
// Optional perf_cycles/perf_cmds outputs are enabled by defining SCHED_PERF_CNT_EN.
module ntt_cmd_sched
  import ntt_cmd_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [3:0]                    cmd_pmax,
  output logic                          ctrl_start,
  output logic [2:0]                    ctrl_set_state,
  output logic [3:0]                    ctrl_p_max,
  input  logic [2:0]                    ctrl_cur_state,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    done_op,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [19:0]                   perf_cycles,
  output logic [15:0]                   perf_cmds
`endif
);

  localparam int AW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // S_ACK is entered one cycle after the start pulse, hence the -2
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t  state;
  cmd_t          push_cmd;
  cmd_t          head;
  logic [CMD_W-1:0] head_bits;
  logic          fifo_empty;
  logic          pop;
  logic [1:0]    head_chk;
  logic [AW-1:0] ack_cnt;
  logic [GW-1:0] gap_cnt;

  assign push_cmd = '{op: cmd_op, pmax: cmd_pmax};
  assign head     = cmd_t'(head_bits);
  assign pop      = (state == S_IDLE) && !fifo_empty;
  assign head_chk = cmd_check(head);
  assign busy     = (state != S_IDLE) || (fifo_count != '0);

  ntt_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .push_data  (push_cmd),
    .pop        (pop),
    .head       (head_bits),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      ctrl_start     <= 1'b0;
      ctrl_set_state <= IDLE;
      ctrl_p_max     <= 4'd0;
      done           <= 1'b0;
      done_op        <= 3'd0;
      err            <= 1'b0;
      err_code       <= ERR_NONE;
      ack_cnt        <= '0;
      gap_cnt        <= '0;
    end else begin
      ctrl_start <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (head_chk != ERR_NONE) begin
              err      <= 1'b1;
              err_code <= head_chk;
            end else begin
              // set_state/p_max stay untouched until the next accepted command
              ctrl_set_state <= head.op;
              ctrl_p_max     <= head.pmax;
              ctrl_start     <= 1'b1;
              state          <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          ack_cnt <= '0;
          state   <= S_ACK;
        end
        S_ACK: begin
          if (ctrl_cur_state != IDLE) begin
            state <= S_RUN;
          end else if (ack_cnt == ACK_LAST) begin
            err      <= 1'b1;
            err_code <= ERR_ACK;
            state    <= S_IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // EPL_* states are non-IDLE, so the run only ends on a true IDLE
          if (ctrl_cur_state == IDLE) begin
            done    <= 1'b1;
            done_op <= ctrl_set_state;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [19:0] run_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt     <= 20'd0;
      perf_cycles <= 20'd0;
      perf_cmds   <= 16'd0;
    end else begin
      if (state == S_IDLE)
        run_cnt <= 20'd0;
      else if (state == S_ISSUE || state == S_ACK || state == S_RUN)
        run_cnt <= run_cnt + 1'b1;
      // run_cnt is 0 in the start cycle; +1 accounts for the done cycle itself
      if (state == S_RUN && ctrl_cur_state == IDLE) begin
        perf_cycles <= run_cnt + 1'b1;
        perf_cmds   <= perf_cmds + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ntt_cmd_sched.sv
// tb/tb_ntt_cmd_sched.sv - randomized self-checking bench for ntt_cmd_sched with a behavioural controller model
module tb_ntt_cmd_sched;

  localparam int FIFO_DEPTH  = 4;
  localparam int ACK_TIMEOUT = 4;
  localparam int GAP_CYCLES  = 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_pmax;
  logic        ctrl_start;
  logic [2:0]  ctrl_set_state;
  logic [3:0]  ctrl_p_max;
  logic [2:0]  ctrl_cur_state;
  logic        busy;
  logic        done;
  logic [2:0]  done_op;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  fifo_count;
`ifdef SCHED_PERF_CNT_EN
  logic [19:0] perf_cycles;
  logic [15:0] perf_cmds;
`endif

  always #5 clk = ~clk;

  ntt_cmd_sched #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_pmax       (cmd_pmax),
    .ctrl_start     (ctrl_start),
    .ctrl_set_state (ctrl_set_state),
    .ctrl_p_max     (ctrl_p_max),
    .ctrl_cur_state (ctrl_cur_state),
    .busy           (busy),
    .done           (done),
    .done_op        (done_op),
    .err            (err),
    .err_code       (err_code),
    .fifo_count     (fifo_count)
`ifdef SCHED_PERF_CNT_EN
    ,
    .perf_cycles    (perf_cycles),
    .perf_cmds      (perf_cmds)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int op;
    int pmax;
    int run_len;
    bit noack;
  } cmd_s;

  cmd_s exp_q[$];

  // 0 = accepted, otherwise the error code the command must produce
  function automatic int outcome(input cmd_s c);
    if (!(c.op == 1 || c.op == 3)) return 1;
    if (c.pmax < 1 || c.pmax > 9) return 2;
    return 0;
  endfunction

  cmd_s fl;
  bit   fl_valid = 0;
  bit   ctl_go = 0;
  int   ctl_remain = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   idle_cyc = 0;
  int   last_done_cyc = -100;
  bit   stable_ok = 1;
  int   n_start = 0;
  int   n_done = 0;
  int   n_done_raw = 0;
  int   n_err_raw = 0;

  // Controller model and event scoreboard, sampled 1 time unit after each edge
  initial begin
    ctrl_cur_state = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rstn) begin
        exp_q.delete();
        fl_valid = 0;
        ctl_go = 0;
        ctl_remain = 0;
        ctrl_cur_state = 3'd0;
      end else begin
        if (ctl_go) begin
          ctl_go = 0;
          ctl_remain = fl.run_len;
          ctrl_cur_state = fl.op[2:0];
        end else if (ctl_remain > 0) begin
          ctl_remain--;
          if (ctl_remain == 0) begin
            ctrl_cur_state = 3'd0;
            idle_cyc = cyc;
          end else if (ctl_remain <= 2) begin
            ctrl_cur_state = (fl.op == 1) ? 3'd5 : 3'd6;
          end
        end

        if (fl_valid && (ctrl_set_state !== fl.op[2:0] || ctrl_p_max !== fl.pmax[3:0]))
          stable_ok = 0;

        if (ctrl_start) begin
          n_start++;
          chk("start_while_busy", fl_valid, 0);
          chk("start_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            fl = exp_q.pop_front();
            chk("start_legal", outcome(fl), 0);
            chk("set_state", ctrl_set_state, fl.op);
            chk("p_max", ctrl_p_max, fl.pmax);
            chk("issue_gap", (cyc - last_done_cyc - 1) >= GAP_CYCLES, 1);
            fl_valid = 1;
            start_cyc = cyc;
            stable_ok = 1;
            ctl_go = !fl.noack;
          end
        end

        if (err) begin
          n_err_raw++;
          if (fl_valid) begin
            chk("ack_to_code", err_code, 3);
            chk("ack_to_expected", fl.noack, 1);
            chk("ack_to_time", cyc - start_cyc, ACK_TIMEOUT);
            fl_valid = 0;
          end else begin
            chk("err_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              cmd_s c;
              c = exp_q.pop_front();
              chk("err_code", err_code, outcome(c));
            end
          end
        end

        if (done) begin
          n_done_raw++;
          chk("done_in_flight", fl_valid, 1);
          if (fl_valid) begin
            n_done++;
            chk("done_op", done_op, fl.op);
            chk("done_expected", fl.noack, 0);
            chk("done_latency", cyc - idle_cyc, 1);
            chk("run_stable", stable_ok, 1);
`ifdef SCHED_PERF_CNT_EN
            chk("perf_cycles", perf_cycles, cyc - start_cyc);
            chk("perf_cmds", perf_cmds, n_done & 16'hffff);
`endif
            fl_valid = 0;
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int op, input int pmax, input int run_len, input bit noack);
    int w = 0;
    cmd_s c;
    while (!cmd_ready && w < 300) begin
      tick();
      w++;
    end
    chk("push_ready", cmd_ready, 1);
    c.op = op;
    c.pmax = pmax;
    c.run_len = run_len;
    c.noack = noack;
    exp_q.push_back(c);
    cmd_valid = 1'b1;
    cmd_op = op[2:0];
    cmd_pmax = pmax[3:0];
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int w = 0;
    while ((busy || fl_valid || exp_q.size() != 0 || ctl_remain != 0) && w < budget) begin
      tick();
      w++;
    end
    chk(tag, w < budget, 1);
    chk("drain_count", fifo_count, 0);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, ctrl_start, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_set_state"}, ctrl_set_state, 0);
    chk({tag, "_p_max"}, ctrl_p_max, 0);
    chk({tag, "_done_op"}, done_op, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int e0;
    int s0;
    int w;
    int exp_done;
    int exp_err;

    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_pmax = 4'd0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rstn = 1'b1;
    repeat (2) tick();

    // Single NTT, 40-cycle run
    s0 = n_start;
    d0 = n_done;
    push(1, 3, 40, 0);
    w = 0;
    while (!done && w < 300) begin
      tick();
      w++;
    end
    chk("s1_done_seen", done, 1);
    chk("s1_done_op", done_op, 1);
    tick();
    chk("s1_busy_after_done", busy, 0);
    drain("s1_drain", 300);
    chk("s1_starts", n_start - s0, 1);
    chk("s1_dones", n_done - d0, 1);

    // Fill the FIFO behind a long-running command
    d0 = n_done;
    push(1, 8, 30, 0);
    w = 0;
    while (!fl_valid && w < 50) begin
      tick();
      w++;
    end
    chk("s2_first_started", fl_valid, 1);
    push(1, 8, 6, 0);
    push(3, 8, 6, 0);
    push(1, 8, 6, 0);
    push(3, 8, 6, 0);
    chk("s2_full_ready", cmd_ready, 0);
    chk("s2_full_count", fifo_count, 4);
    chk("s2_busy", busy, 1);
    drain("s2_drain", 600);
    chk("s2_dones", n_done - d0, 5);

    // Illegal opcode, illegal pmax, then a legal INTT
    d0 = n_done;
    e0 = n_err_raw;
    push(2, 3, 10, 0);
    push(1, 0, 10, 0);
    push(3, 2, 10, 0);
    drain("s3_drain", 300);
    chk("s3_errs", n_err_raw - e0, 2);
    chk("s3_dones", n_done - d0, 1);
    chk("s3_last_op", done_op, 3);

    // Controller never acknowledges; the next command still runs
    d0 = n_done;
    e0 = n_err_raw;
    push(1, 5, 0, 1);
    push(3, 4, 5, 0);
    drain("s4_drain", 300);
    chk("s4_errs", n_err_raw - e0, 1);
    chk("s4_dones", n_done - d0, 1);

    // Reset while running with two commands queued
    push(1, 4, 60, 0);
    w = 0;
    while (!(fl_valid && ctl_remain > 0) && w < 50) begin
      tick();
      w++;
    end
    repeat (5) tick();
    push(3, 5, 10, 0);
    push(1, 6, 10, 0);
    chk("s5_queued", fifo_count, 2);
    @(posedge clk);
    #4;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    chk("s5_count_after", fifo_count, 0);
    d0 = n_done_raw;
    repeat (20) tick();
    chk("s5_no_done", n_done_raw - d0, 0);
    chk("s5_idle", busy, 0);

    // Randomized command stream
    d0 = n_done;
    e0 = n_err_raw;
    exp_done = 0;
    exp_err = 0;
    for (int i = 0; i < 30; i++) begin
      cmd_s c;
      int r;
      r = $urandom_range(0, 9);
      c.op = (r < 4) ? 1 : (r < 8) ? 3 : $urandom_range(0, 7);
      c.pmax = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 9);
      c.run_len = $urandom_range(1, 12);
      c.noack = (outcome(c) == 0) && ($urandom_range(0, 7) == 0);
      if (outcome(c) != 0 || c.noack) exp_err++;
      else exp_done++;
      push(c.op, c.pmax, c.run_len, c.noack);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("rand_drain", 3000);
    chk("rand_dones", n_done - d0, exp_done);
    chk("rand_errs", n_err_raw - e0, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
